reg6_arbiter: RTL and testbench
===============================

REG6_ARBITER -- requirements
Module: reg6_arbiter

Interface
REQ-001 Parameter WIDTH, default 6, sets the data width of every data port.
REQ-002 Parameter TIMEOUT, default 15, sets the maximum number of WAIT cycles before an abort.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port `clk`: input, 1 bit, rising-edge clock.
REQ-005 Port `rst`: input, 1 bit, asynchronous active-high reset.
REQ-006 Port `req`: input, 3 bits; bit i is requester i's level request (four-phase).
REQ-007 Ports `data0`, `data1`, `data2`: input, WIDTH bits each, write data of requester 0, 1 and 2.
REQ-008 Port `gnt`: output, 3 bits, one-hot grant, held from ISSUE through RELEASE.
REQ-009 Port `ack`: output, 3 bits, one-cycle completion pulse to the granted requester.
REQ-010 Port `err`: output, 1 bit, one-cycle timeout-abort pulse.
REQ-011 Port `reg_en`: output, 1 bit, enable to the shared 6-bit handshake register.
REQ-012 Port `reg_data`: output, WIDTH bits, data to the shared register.
REQ-013 Port `reg_fim`: input, 1 bit, completion flag from the shared register.
REQ-014 Port `busy`: output, 1 bit, high in every state except IDLE.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, ISSUE, WAIT, ACK, RELEASE.
REQ-016 IDLE with req != 0 SHALL select one requester round-robin, searching from (last+1) mod 3 upward, and go to ISSUE on the next edge.
- On that edge: gnt <= one-hot of the winner; reg_data <= the winner's data.
REQ-017 IDLE with req == 0 SHALL stay in IDLE with all outputs at their reset values.
REQ-018 ISSUE SHALL last exactly one cycle.
- reg_en = 1 from ISSUE onward.
- Timeout counter cleared.
- Next state WAIT.
REQ-019 WAIT SHALL hold reg_en = 1, gnt and reg_data stable, and increment the timeout counter each cycle.
REQ-020 WAIT with reg_fim = 1 sampled SHALL go to ACK.
REQ-021 WAIT with counter == TIMEOUT-1 and reg_fim = 0 SHALL take the timeout path:
- err = 1 for one cycle;
- reg_en = 0, gnt = 0;
- last <= granted index;
- next state IDLE; no ack.
REQ-022 If reg_fim and the timeout occur in the same cycle, completion (ACK) SHALL win.
REQ-023 ACK SHALL last exactly one cycle:
- ack[g] = 1, reg_en = 0;
- last <= g;
- next state RELEASE.
REQ-024 RELEASE SHALL keep gnt[g] and wait until req[g] = 0, then go to IDLE with gnt = 0; other requests are ignored until then.
REQ-025 Deasserting req[g] during ISSUE or WAIT SHALL NOT abort the transfer; data already latched completes normally.
REQ-026 Data inputs changing after the grant edge SHALL NOT affect reg_data.
REQ-027 Latency from req rising in IDLE to reg_en = 1 SHALL be exactly 2 rising edges.
REQ-028 gnt SHALL always be one-hot or zero; ack and err SHALL never be high in the same cycle.

Reset
REQ-029 While rst = 1, immediately and regardless of clock:
- state = IDLE;
- gnt = 0, ack = 0, err = 0, reg_en = 0, reg_data = 0, busy = 0;
- timeout counter = 0;
- last = 2, so requester 0 has first priority.
REQ-030 Reset asserted in any state, including mid-WAIT, SHALL abandon the transfer with no ack or err pulse.

Verification
REQ-031 Single request: after reset, req = 001, data0 = 101010, reg_fim high 3 cycles after reg_en -> expected response:
- gnt = 001;
- reg_data = 101010;
- reg_en high for ISSUE + WAIT;
- ack = 001 for one cycle;
- IDLE once req drops.
REQ-032 Contention: req = 111 held and each requester re-requesting after release -> grant order 0, 1, 2, 0.
- data0/1/2 = 000001/000010/000100 appear on reg_data in that order.
REQ-033 Timeout: req = 010, reg_fim tied 0 -> err pulses exactly TIMEOUT cycles after entering WAIT; no ack; reg_en falls; next grant order starts at requester 2.
REQ-034 Early drop: req = 100 deasserted during WAIT, data2 = 110000 changed to 000011 after the grant -> reg_data stays 110000; ack = 100 on reg_fim; direct return to IDLE.
REQ-035 Reset mid-operation: rst pulsed during WAIT -> all outputs 0 asynchronously; a subsequent req = 111 grants requester 0 first.
REQ-036 Collision: reg_fim rises on the final timeout cycle -> ack pulses, err stays 0.

Source files
------------

// File: rtl/reg6_arbiter.sv
// Three-requester round-robin arbiter driving a shared handshake register.
// Each grant is held until the winner drops its request; a stalled register aborts after TIMEOUT wait cycles.
module reg6_arbiter #(
    parameter int WIDTH   = 6,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic [2:0]       gnt,
    output logic [2:0]       ack,
    output logic             err,
    output logic             reg_en,
    output logic [WIDTH-1:0] reg_data,
    input  logic             reg_fim,
    output logic             busy
);

    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ACK,
        ST_RELEASE
    } state_e;

    state_e           state_q;
    logic [2:0]       gnt_q;
    logic [2:0]       ack_q;
    logic             err_q;
    logic             reg_en_q;
    logic [WIDTH-1:0] reg_data_q;
    logic [CW-1:0]    cnt_q;
    logic [1:0]       last_q;
    logic [1:0]       gidx_q;

    logic [1:0]       cand1_d;
    logic [1:0]       cand2_d;
    logic [1:0]       cand3_d;
    logic [1:0]       win_idx_d;
    logic [2:0]       win_oh_d;
    logic [WIDTH-1:0] win_data_d;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Search order starts one past the last served requester and wraps mod 3.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch can be inferred.
        cand1_d = rr_next(last_q);
        cand2_d = rr_next(cand1_d);
        cand3_d = rr_next(cand2_d);
        if (req[cand1_d])      win_idx_d = cand1_d;
        else if (req[cand2_d]) win_idx_d = cand2_d;
        else                   win_idx_d = cand3_d;
        win_oh_d = 3'b001 << win_idx_d;
        case (win_idx_d)
            2'd0:    win_data_d = data0;
            2'd1:    win_data_d = data1;
            default: win_data_d = data2;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            reg_en_q   <= 1'b0;
            reg_data_q <= '0;
            cnt_q      <= '0;
            last_q     <= 2'd2;
            gidx_q     <= 2'd0;
        end else begin
            ack_q <= '0;
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        state_q    <= ST_ISSUE;
                        gnt_q      <= win_oh_d;
                        gidx_q     <= win_idx_d;
                        reg_data_q <= win_data_d;
                    end
                end
                ST_ISSUE: begin
                    state_q  <= ST_WAIT;
                    reg_en_q <= 1'b1;
                    cnt_q    <= '0;
                end
                ST_WAIT: begin
                    // Completion is checked first so it wins over a coincident timeout.
                    if (reg_fim) begin
                        state_q  <= ST_ACK;
                        ack_q    <= gnt_q;
                        reg_en_q <= 1'b0;
                        last_q   <= gidx_q;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q    <= ST_IDLE;
                        err_q      <= 1'b1;
                        reg_en_q   <= 1'b0;
                        gnt_q      <= '0;
                        reg_data_q <= '0;
                        last_q     <= gidx_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!req[gidx_q]) begin
                        state_q    <= ST_IDLE;
                        gnt_q      <= '0;
                        reg_data_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign ack      = ack_q;
    assign err      = err_q;
    assign reg_en   = reg_en_q;
    assign reg_data = reg_data_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reg6_arbiter.sv
// Cycle-by-cycle bench for reg6_arbiter: a vector table plus hand-built timeout, drop, reset and collision sequences.
module tb_reg6_arbiter;

    localparam int W  = 6;
    localparam int TO = 15;

    logic         clk     = 1'b0;
    logic         rst     = 1'b1;
    logic [2:0]   req     = 3'b000;
    logic [W-1:0] data0   = '0;
    logic [W-1:0] data1   = '0;
    logic [W-1:0] data2   = '0;
    logic         reg_fim = 1'b0;
    logic [2:0]   gnt;
    logic [2:0]   ack;
    logic         err;
    logic         reg_en;
    logic [W-1:0] reg_data;
    logic         busy;

    always #5 clk = ~clk;

    reg6_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data0    (data0),
        .data1    (data1),
        .data2    (data2),
        .gnt      (gnt),
        .ack      (ack),
        .err      (err),
        .reg_en   (reg_en),
        .reg_data (reg_data),
        .reg_fim  (reg_fim),
        .busy     (busy)
    );

    typedef struct packed {
        logic [2:0]   gnt;
        logic [2:0]   ack;
        logic         err;
        logic         en;
        logic [W-1:0] data;
        logic         busy;
    } exp_t;

    typedef struct packed {
        logic         rst;
        logic [2:0]   req;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        logic [W-1:0] d2;
        logic         fim;
        exp_t         e;
    } vec_t;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];
    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [2:0] rq, logic [W-1:0] d0, logic [W-1:0] d1,
                                logic [W-1:0] d2, logic f, logic [2:0] g, logic [2:0] a,
                                logic e, logic en, logic [W-1:0] rd, logic b);
        vec_t v;
        v.rst    = r;
        v.req    = rq;
        v.d0     = d0;
        v.d1     = d1;
        v.d2     = d2;
        v.fim    = f;
        v.e.gnt  = g;
        v.e.ack  = a;
        v.e.err  = e;
        v.e.en   = en;
        v.e.data = rd;
        v.e.busy = b;
        return v;
    endfunction

    function automatic exp_t sample();
        exp_t s;
        s.gnt  = gnt;
        s.ack  = ack;
        s.err  = err;
        s.en   = reg_en;
        s.data = reg_data;
        s.busy = busy;
        return s;
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got gnt=%b ack=%b err=%b reg_en=%b reg_data=%b busy=%b, expected gnt=%b ack=%b err=%b reg_en=%b reg_data=%b busy=%b",
                     name, got.gnt, got.ack, got.err, got.en, got.data, got.busy,
                     exp.gnt, exp.ack, exp.err, exp.en, exp.data, exp.busy);
        end
    endtask

    // Inputs change on the falling edge; outputs are compared 1 time unit after the rising edge.
    task automatic apply(input string name, input vec_t v);
        @(negedge clk);
        rst     = v.rst;
        req     = v.req;
        data0   = v.d0;
        data1   = v.d1;
        data2   = v.d2;
        reg_fim = v.fim;
        sb.push_back(v.e);
        @(posedge clk);
        #1;
        check(name, sample(), sb.pop_front());
    endtask

    localparam logic [W-1:0] D0S = 6'b101010;
    localparam logic [W-1:0] DT1 = 6'h15;
    localparam logic [W-1:0] DT2 = 6'h2c;
    localparam logic [W-1:0] DE2 = 6'b110000;
    localparam logic [W-1:0] DE2B = 6'b000011;
    localparam logic [W-1:0] DR0 = 6'h11;
    localparam logic [W-1:0] DR1 = 6'h22;
    localparam logic [W-1:0] DR2 = 6'h33;
    localparam logic [W-1:0] DC0 = 6'h07;

    int           order[4] = '{0, 1, 2, 0};
    logic [W-1:0] dval[3]  = '{6'b000001, 6'b000010, 6'b000100};
    exp_t         zero_e   = '0;
    logic [2:0]   oh;

    initial begin
        // Single request: issue, two-edge latency to reg_en, fim three cycles later, ack, release.
        tbl.push_back(mk(1'b1, 3'b000, D0S, '0, '0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, '0,  1'b0));
        tbl.push_back(mk(1'b0, 3'b001, D0S, '0, '0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, D0S, 1'b1));
        tbl.push_back(mk(1'b0, 3'b001, D0S, '0, '0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b1, D0S, 1'b1));
        tbl.push_back(mk(1'b0, 3'b001, D0S, '0, '0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b1, D0S, 1'b1));
        tbl.push_back(mk(1'b0, 3'b001, D0S, '0, '0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b1, D0S, 1'b1));
        tbl.push_back(mk(1'b0, 3'b001, D0S, '0, '0, 1'b1, 3'b001, 3'b001, 1'b0, 1'b0, D0S, 1'b1));
        tbl.push_back(mk(1'b0, 3'b001, D0S, '0, '0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, D0S, 1'b1));
        tbl.push_back(mk(1'b0, 3'b001, D0S, '0, '0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, D0S, 1'b1));
        tbl.push_back(mk(1'b0, 3'b000, D0S, '0, '0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, '0,  1'b0));
        tbl.push_back(mk(1'b0, 3'b000, D0S, '0, '0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, '0,  1'b0));

        // Contention from reset: req=111, grants rotate 0,1,2,0 with each winner briefly dropping.
        tbl.push_back(mk(1'b1, 3'b000, dval[0], dval[1], dval[2], 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, '0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            oh = 3'b001 << order[i];
            tbl.push_back(mk(1'b0, 3'b111, dval[0], dval[1], dval[2], 1'b0, oh, 3'b000, 1'b0, 1'b0, dval[order[i]], 1'b1));
            tbl.push_back(mk(1'b0, 3'b111, dval[0], dval[1], dval[2], 1'b0, oh, 3'b000, 1'b0, 1'b1, dval[order[i]], 1'b1));
            tbl.push_back(mk(1'b0, 3'b111, dval[0], dval[1], dval[2], 1'b1, oh, oh,     1'b0, 1'b0, dval[order[i]], 1'b1));
            tbl.push_back(mk(1'b0, 3'b111, dval[0], dval[1], dval[2], 1'b0, oh, 3'b000, 1'b0, 1'b0, dval[order[i]], 1'b1));
            tbl.push_back(mk(1'b0, 3'b111 & ~oh, dval[0], dval[1], dval[2], 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, '0, 1'b0));
        end

        for (int i = 0; i < tbl.size(); i++)
            apply($sformatf("tbl%0d", i), tbl[i]);

        // Timeout: requester 1 never completes; err after TO wait cycles, then requester 2 is next.
        apply("to_reset", mk(1'b1, 3'b000, '0, DT1, DT2, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, '0,  1'b0));
        apply("to_issue", mk(1'b0, 3'b010, '0, DT1, DT2, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, DT1, 1'b1));
        apply("to_wait0", mk(1'b0, 3'b010, '0, DT1, DT2, 1'b0, 3'b010, 3'b000, 1'b0, 1'b1, DT1, 1'b1));
        for (int n = 1; n < TO; n++)
            apply($sformatf("to_wait%0d", n), mk(1'b0, 3'b010, '0, DT1, DT2, 1'b0, 3'b010, 3'b000, 1'b0, 1'b1, DT1, 1'b1));
        apply("to_err",   mk(1'b0, 3'b010, '0, DT1, DT2, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, '0,  1'b0));
        apply("to_next",  mk(1'b0, 3'b111, '0, DT1, DT2, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, DT2, 1'b1));

        // Early drop: requester 2 releases req mid-transfer and its data changes after the grant.
        apply("ed_reset", mk(1'b1, 3'b000, '0, '0, DE2,  1'b0, 3'b000, 3'b000, 1'b0, 1'b0, '0,  1'b0));
        apply("ed_issue", mk(1'b0, 3'b100, '0, '0, DE2,  1'b0, 3'b100, 3'b000, 1'b0, 1'b0, DE2, 1'b1));
        apply("ed_wait0", mk(1'b0, 3'b100, '0, '0, DE2B, 1'b0, 3'b100, 3'b000, 1'b0, 1'b1, DE2, 1'b1));
        apply("ed_wait1", mk(1'b0, 3'b000, '0, '0, DE2B, 1'b0, 3'b100, 3'b000, 1'b0, 1'b1, DE2, 1'b1));
        apply("ed_ack",   mk(1'b0, 3'b000, '0, '0, DE2B, 1'b1, 3'b100, 3'b100, 1'b0, 1'b0, DE2, 1'b1));
        apply("ed_rel",   mk(1'b0, 3'b000, '0, '0, DE2B, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, DE2, 1'b1));
        apply("ed_idle",  mk(1'b0, 3'b000, '0, '0, DE2B, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, '0,  1'b0));

        // Asynchronous reset mid-wait, then requester 0 has first priority again.
        apply("ar_reset", mk(1'b1, 3'b000, DR0, DR1, DR2, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, '0,  1'b0));
        apply("ar_issue", mk(1'b0, 3'b111, DR0, DR1, DR2, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, DR0, 1'b1));
        apply("ar_wait0", mk(1'b0, 3'b111, DR0, DR1, DR2, 1'b0, 3'b001, 3'b000, 1'b0, 1'b1, DR0, 1'b1));
        apply("ar_wait1", mk(1'b0, 3'b111, DR0, DR1, DR2, 1'b0, 3'b001, 3'b000, 1'b0, 1'b1, DR0, 1'b1));
        #2;
        rst = 1'b1;
        #1;
        sb.push_back(zero_e);
        check("ar_async", sample(), sb.pop_front());
        apply("ar_regrant", mk(1'b0, 3'b111, DR0, DR1, DR2, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, DR0, 1'b1));

        // Collision: fim arrives on the last timeout cycle, so ack wins and err stays low.
        apply("co_reset", mk(1'b1, 3'b000, DC0, '0, '0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, '0,  1'b0));
        apply("co_issue", mk(1'b0, 3'b001, DC0, '0, '0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, DC0, 1'b1));
        apply("co_wait0", mk(1'b0, 3'b001, DC0, '0, '0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b1, DC0, 1'b1));
        for (int n = 1; n < TO; n++)
            apply($sformatf("co_wait%0d", n), mk(1'b0, 3'b001, DC0, '0, '0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b1, DC0, 1'b1));
        apply("co_ack",   mk(1'b0, 3'b001, DC0, '0, '0, 1'b1, 3'b001, 3'b001, 1'b0, 1'b0, DC0, 1'b1));
        apply("co_rel",   mk(1'b0, 3'b001, DC0, '0, '0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, DC0, 1'b1));
        apply("co_idle",  mk(1'b0, 3'b000, DC0, '0, '0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, '0,  1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
